// File: rtl/layer_serializer.sv
// layer_serializer: ping-pong buffers parallel neuron vectors and streams them one lane per cycle.
module layer_serializer #(
  parameter int NEURON_NUM = 96,
  parameter int IN_W       = 8,
  parameter int OUT_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NEURON_NUM*IN_W-1:0] in_dat,
  input  logic                       in_valid,
  output logic [OUT_W-1:0]           out_dat,
  output logic                       out_valid,
  output logic                       out_last,
  output logic                       busy,
  output logic                       overflow
);
  localparam int VW = NEURON_NUM * IN_W;
  localparam int LW = NEURON_NUM > 1 ? $clog2(NEURON_NUM) : 1;
  localparam logic [LW-1:0] LAST = LW'(NEURON_NUM - 1);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t          state_q, state_d;
  logic [LW-1:0]   lane_q, lane_d, nlane;
  logic [1:0]      full_q, full_d;
  logic            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OUT_W-1:0] out_dat_q, out_dat_d;
  logic            out_valid_q, out_valid_d, out_last_q, out_last_d, overflow_q, overflow_d;
  logic [VW-1:0]   bank_q [2];
  logic [VW-1:0]   src;
  logic [IN_W-1:0] samp;
  logic            fin, wr_en, nb, cont, start;
  // lane_q is the lane currently on out_dat; a starting bank may be bypassed straight from in_dat
  always_comb begin
    fin         = state_q == STREAM && lane_q == LAST;
    wr_en       = in_valid && (!full_q[wr_ptr_q] || (fin && rd_ptr_q == wr_ptr_q));
    nb          = fin ? ~rd_ptr_q : rd_ptr_q;
    cont        = state_q == STREAM && !fin;
    start       = (state_q == IDLE || fin) && (full_q[nb] || (wr_en && wr_ptr_q == nb));
    nlane       = cont ? lane_q + 1'b1 : '0;
    src         = cont ? bank_q[rd_ptr_q] : (wr_en && wr_ptr_q == nb) ? in_dat : bank_q[nb];
    samp        = src[nlane*IN_W +: IN_W];
    state_d     = (cont || start) ? STREAM : IDLE;
    lane_d      = nlane;
    out_valid_d = cont || start;
    out_last_d  = (cont || start) && nlane == LAST;
    out_dat_d   = out_valid_d ? OUT_W'(signed'(samp)) : out_dat_q;
    full_d      = full_q;
    if (fin) full_d[rd_ptr_q] = 1'b0;
    if (wr_en) full_d[wr_ptr_q] = 1'b1;
    rd_ptr_d    = rd_ptr_q ^ fin;
    wr_ptr_d    = wr_ptr_q ^ wr_en;
    overflow_d  = overflow_q | (in_valid & ~wr_en);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lane_q      <= '0;
      full_q      <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      out_dat_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      full_q      <= full_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_dat_q   <= out_dat_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      overflow_q  <= overflow_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) bank_q[wr_ptr_q] <= in_dat;
  end
  assign out_dat   = out_dat_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign overflow  = overflow_q;
  assign busy      = |full_q || state_q == STREAM;
endmodule

// File: tb/tb_layer_serializer.sv
// tb_layer_serializer: randomized and directed checks of layer_serializer against a schedule-based model.
module tb_layer_serializer;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0;
  logic [31:0] in_dat = '0;
  logic [15:0] out_dat;
  logic        out_valid, out_last, busy, overflow;
  int          cyc = 0, total = 0, bad = 0, last_end = -10;
  logic [15:0] beats [int];
  bit          lasts [int];
  int          acc_q [$], end_q [$];
  bit          m_ovf = 1'b0;
  logic [15:0] m_dat = '0;

  always #5 clk = ~clk;

  layer_serializer #(.NEURON_NUM(4), .IN_W(8), .OUT_W(16)) dut (
    .clk(clk), .rst(rst), .in_dat(in_dat), .in_valid(in_valid),
    .out_dat(out_dat), .out_valid(out_valid), .out_last(out_last),
    .busy(busy), .overflow(overflow)
  );

  // model: a vector is accepted when fewer than two accepted vectors are still unfinished,
  // and streams at the earliest cycle after both its arrival and the previous stream
  task automatic step(input bit r, input bit v, input logic [31:0] d);
    bit drop = 1'b0;
    int held = 0;
    int s;
    @(negedge clk);
    rst = r; in_valid = v; in_dat = d;
    if (r) begin
      beats.delete(); lasts.delete(); acc_q.delete(); end_q.delete(); last_end = -10;
    end else if (v) begin
      foreach (end_q[i]) if (end_q[i] > cyc) held++;
      if (held < 2) begin
        s = (cyc + 1 > last_end + 1) ? cyc + 1 : last_end + 1;
        for (int k = 0; k < 4; k++) beats[s+k] = {{8{d[k*8+7]}}, d[k*8 +: 8]};
        lasts[s+3] = 1'b1;
        acc_q.push_back(cyc); end_q.push_back(s + 3); last_end = s + 3;
      end else drop = 1'b1;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (r) begin m_ovf = 1'b0; m_dat = '0; end
    if (drop) m_ovf = 1'b1;
    if (beats.exists(cyc)) m_dat = beats[cyc];
  endtask

  function automatic logic [3:0] exp_ctl();
    bit b = 1'b0;
    foreach (acc_q[i]) if (acc_q[i] < cyc && cyc <= end_q[i]) b = 1'b1;
    return {beats.exists(cyc) ? 1'b1 : 1'b0, lasts.exists(cyc) ? 1'b1 : 1'b0, b, m_ovf};
  endfunction

  task automatic test_reset();
    step(1, 0, 0);
    step(1, 1, 32'h12345678);
    total++;
    if ({out_valid, out_last, busy, overflow} !== 4'b0 || out_dat !== 16'h0) begin
      bad++; $display("FAIL reset got v/l/b/o=%b dat=%h exp 0000 0000", {out_valid, out_last, busy, overflow}, out_dat);
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0);
      total++;
      if ({out_valid, out_last, busy} !== 3'b0 || out_dat !== 16'h0) begin
        bad++; $display("FAIL idle cyc=%0d got v/l/b=%b dat=%h exp 000 0000", cyc, {out_valid, out_last, busy}, out_dat);
      end
    end
  endtask

  task automatic test_single();
    logic [15:0] vals [4] = '{16'h007F, 16'hFF80, 16'h0001, 16'hFFFF};
    step(0, 1, 32'hFF01807F);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (out_valid !== 1'b1 || out_last !== (k == 3) || out_dat !== vals[k]) begin
        bad++; $display("FAIL single lane%0d got v=%b l=%b dat=%h exp v=1 l=%0d dat=%h", k, out_valid, out_last, out_dat, k == 3, vals[k]);
      end
      step(0, 0, 0);
    end
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_dat !== 16'hFFFF) begin
      bad++; $display("FAIL single_after got v=%b b=%b dat=%h exp v=0 b=0 dat=ffff", out_valid, busy, out_dat);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, i < 2, $urandom);
      n += out_valid;
      total++;
      if ({out_valid, out_last, busy, overflow} !== exp_ctl() || out_dat !== m_dat) begin
        bad++; $display("FAIL b2b cyc=%0d got v/l/b/o=%b dat=%h exp %b %h", cyc, {out_valid, out_last, busy, overflow}, out_dat, exp_ctl(), m_dat);
      end
    end
    total++;
    if (n !== 8) begin bad++; $display("FAIL b2b_beats got %0d exp 8", n); end
  endtask

  task automatic test_boundary();
    int n = 0;
    for (int i = 0; i < 18; i++) begin
      step(0, i == 0 || i == 1 || i == 4, $urandom);
      n += out_valid;
      total++;
      if ({out_valid, out_last, busy, overflow} !== exp_ctl() || out_dat !== m_dat) begin
        bad++; $display("FAIL boundary cyc=%0d got v/l/b/o=%b dat=%h exp %b %h", cyc, {out_valid, out_last, busy, overflow}, out_dat, exp_ctl(), m_dat);
      end
    end
    total++;
    if (n !== 12 || overflow !== 1'b0) begin bad++; $display("FAIL boundary_beats got n=%0d ovf=%b exp 12 0", n, overflow); end
  endtask

  task automatic test_overflow();
    int n = 0;
    for (int i = 0; i < 14; i++) begin
      step(0, i < 3, $urandom);
      n += out_valid;
      total++;
      if ({out_valid, out_last, busy, overflow} !== exp_ctl() || out_dat !== m_dat) begin
        bad++; $display("FAIL overflow cyc=%0d got v/l/b/o=%b dat=%h exp %b %h", cyc, {out_valid, out_last, busy, overflow}, out_dat, exp_ctl(), m_dat);
      end
    end
    total++;
    if (n !== 8 || overflow !== 1'b1) begin bad++; $display("FAIL overflow_beats got n=%0d ovf=%b exp 8 1", n, overflow); end
  endtask

  task automatic test_reset_mid();
    step(0, 1, $urandom);
    step(0, 0, 0);
    step(1, 0, 0);
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
      bad++; $display("FAIL reset_mid got v=%b b=%b o=%b exp 0 0 0", out_valid, busy, overflow);
    end
    for (int i = 0; i < 7; i++) begin
      step(0, i == 0, 32'hA5C3_0F81);
      total++;
      if ({out_valid, out_last, busy, overflow} !== exp_ctl() || out_dat !== m_dat) begin
        bad++; $display("FAIL reset_mid_restart cyc=%0d got v/l/b/o=%b dat=%h exp %b %h", cyc, {out_valid, out_last, busy, overflow}, out_dat, exp_ctl(), m_dat);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(49) == 0, $urandom_range(1), $urandom);
      total++;
      if ({out_valid, out_last, busy, overflow} !== exp_ctl() || out_dat !== m_dat) begin
        bad++; $display("FAIL random cyc=%0d got v/l/b/o=%b dat=%h exp %b %h", cyc, {out_valid, out_last, busy, overflow}, out_dat, exp_ctl(), m_dat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_boundary();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/layer_serializer.md
LAYER_SERIALIZER -- requirements
Module: layer_serializer

Interface
REQ-001 Parameter NEURON_NUM, default 96; number of neuron outputs captured per vector and beats emitted per stream.
REQ-002 Parameter IN_W, default 8; width of each neuron output sample, signed fix [1,7].
REQ-003 Parameter OUT_W, default 16; width of each emitted sample, signed fix [9,7]; OUT_W >= IN_W.
REQ-004 Port clk  input  1; single clock, all logic on its rising edge.
REQ-005 Port rst  input  1; reset, synchronous and active-high.
REQ-006 Port in_dat  input  NEURON_NUM*IN_W; parallel neuron outputs, lane k = bits [k*IN_W +: IN_W].
REQ-007 Port in_valid  input  1; single-cycle strobe, all lanes of in_dat valid this cycle.
REQ-008 Port out_dat  output  OUT_W; serialized sample, registered.
REQ-009 Port out_valid  output  1; out_dat valid this cycle, registered.
REQ-010 Port out_last  output  1; high with out_valid on the final beat (lane NEURON_NUM-1) of a stream.
REQ-011 Port busy  output  1; high while either bank holds unsent data or a stream is in progress.
REQ-012 Port overflow  output  1; sticky drop flag, cleared only by rst.

Function
REQ-013 Two vector banks (ping-pong), each NEURON_NUM x IN_W, each with a full flag; write pointer and read pointer toggle 0/1, both reset to 0.
REQ-014 On in_valid with a free bank, in_dat is captured whole into the bank at the write pointer, its full flag set, and the write pointer toggled.
REQ-015 Read FSM has states IDLE and STREAM, plus a lane counter 0..NEURON_NUM-1.
REQ-016 IDLE -> STREAM when the bank at the read pointer is full; the lane counter starts at 0.
REQ-017 In STREAM, one beat is issued per cycle, lanes 0,1,...,NEURON_NUM-1 in order, with no gaps.
REQ-018 On the last lane, the bank is cleared and the read pointer toggled; FSM goes to STREAM (counter 0) if the other bank is full, else IDLE; the next stream is back-to-back with no bubble.
REQ-019 Latency: in_valid accepted at cycle t into an empty block gives the lane 0 beat at t+1 and the lane NEURON_NUM-1 beat at t+NEURON_NUM.
REQ-020 out_dat = lane sample sign-extended to OUT_W (upper OUT_W-IN_W bits = sample MSB); no scaling, no saturation.
REQ-021 out_dat holds its last value while out_valid = 0.
REQ-022 Bank free rule: a bank is free if its full flag is clear, or it is the bank whose last beat is issued this same cycle.
REQ-023 Simultaneous last beat and in_valid with no other free bank: data is written into the finishing bank and the write pointer toggles; no overflow.
REQ-024 in_valid with no free bank: vector dropped, banks and pointers unchanged, and overflow set from the next cycle.
REQ-025 Data already captured is never corrupted by a later in_valid.
REQ-026 busy = any full flag OR FSM in STREAM.

Reset
REQ-027 When rst is sampled high: out_valid=0, out_last=0, out_dat=0, overflow=0, busy=0, both full flags cleared, pointers=0, lane counter=0, FSM=IDLE.
REQ-028 rst mid-stream aborts immediately; no beat is issued in the cycle after rst is sampled, and buffered vectors are discarded.
REQ-029 Bank storage needs no reset; only control and output registers are reset.

Verification (NEURON_NUM=4, IN_W=8, OUT_W=16)
REQ-030 Single vector: in_dat lanes {0x7F,0x80,0x01,0xFF}, one in_valid pulse -> next 4 cycles out_dat 0x007F,0xFF80,0x0001,0xFFFF; out_last only on the 4th beat; busy low after it.
REQ-031 Back-to-back: two vectors 1 cycle apart -> 8 contiguous beats with no gap, second vector's lane 0 immediately after first's out_last; overflow=0.
REQ-032 Overflow: three in_valid pulses on consecutive cycles -> third vector dropped, overflow=1 held, only 8 beats, values from vectors 1 and 2.
REQ-033 Boundary: vectors A and B fill both banks, then C arrives exactly on A's last beat -> C accepted; beats A,B,C (12) with no gap; overflow=0.
REQ-034 Reset mid-stream: rst high during beat lane 1 -> out_valid=0 the next cycle, busy=0, overflow=0; a new vector then streams from lane 0 with latency 1.
REQ-035 Idle stability: no in_valid for 20 cycles after reset -> out_valid, out_last and busy stay 0, and out_dat stays 0.
